// File: rtl/img_sram_arbiter.sv
// Round-robin arbiter sharing one image SRAM port between three requesters,
// with per-requester grant lock and one-cycle read-data return routing.
module img_sram_arbiter #(
  parameter int X_MAX       = 16,
  parameter int Y_MAX       = 16,
  parameter int PIXEL_DEPTH = 8,
  parameter int NUM_REQ     = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req,
  input  logic [NUM_REQ-1:0]                     lock,
  input  logic [NUM_REQ-1:0]                     wen_req,
  input  logic [NUM_REQ*($clog2(X_MAX)+1)-1:0]   x_req,
  input  logic [NUM_REQ*($clog2(Y_MAX)+1)-1:0]   y_req,
  input  logic [NUM_REQ*PIXEL_DEPTH-1:0]         wdat_req,
  output logic [NUM_REQ-1:0]                     gnt,
  output logic [NUM_REQ-1:0]                     rvalid,
  output logic [PIXEL_DEPTH-1:0]                 rdat,
  output logic [$clog2(X_MAX):0]                 x_addr,
  output logic [$clog2(Y_MAX):0]                 y_addr,
  output logic [PIXEL_DEPTH-1:0]                 wdat,
  output logic                                   wen,
  output logic                                   ren,
  input  logic [PIXEL_DEPTH-1:0]                 rdat_sram
);

  localparam int XW = $clog2(X_MAX) + 1;
  localparam int YW = $clog2(Y_MAX) + 1;

  logic [1:0] rr_ptr;
  logic       lock_vld;
  logic [1:0] lock_idx;
  logic       pend;
  logic [1:0] pend_idx;

  logic       gnt_any;
  logic [1:0] gnt_idx;
  logic [1:0] cand;

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // A live lock (owner still requesting) wins outright; otherwise search
  // upward from rr_ptr, wrapping modulo 3. Nothing is granted during reset.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    cand    = rr_ptr;
    if (!rst) begin
      if (lock_vld && req[lock_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = lock_idx;
      end else begin
        for (int k = 0; k < 3; k++) begin
          if (!gnt_any && req[cand]) begin
            gnt_any = 1'b1;
            gnt_idx = cand;
          end
          cand = next_idx(cand);
        end
      end
    end
  end

  always_comb begin
    gnt    = '0;
    x_addr = '0;
    y_addr = '0;
    wdat   = '0;
    wen    = 1'b0;
    ren    = 1'b0;
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
      x_addr       = x_req[gnt_idx*XW +: XW];
      y_addr       = y_req[gnt_idx*YW +: YW];
      wdat         = wdat_req[gnt_idx*PIXEL_DEPTH +: PIXEL_DEPTH];
      wen          = wen_req[gnt_idx];
      ren          = ~wen_req[gnt_idx];
    end
  end

  // Gating with rst drops a read return that would land in a reset cycle.
  always_comb begin
    rvalid = '0;
    if (pend && !rst) rvalid[pend_idx] = 1'b1;
  end

  assign rdat = rdat_sram;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= 2'd0;
      lock_vld <= 1'b0;
      lock_idx <= 2'd0;
      pend     <= 1'b0;
      pend_idx <= 2'd0;
    end else if (gnt_any) begin
      rr_ptr   <= next_idx(gnt_idx);
      lock_vld <= lock[gnt_idx];
      lock_idx <= gnt_idx;
      pend     <= ~wen_req[gnt_idx];
      pend_idx <= gnt_idx;
    end else begin
      pend     <= 1'b0;
    end
  end

endmodule
